// File: rtl/code_arbiter.sv
// code_arbiter: round-robin owner of the two-channel code datapath.
// Runs Slt/En for N steps on behalf of one requester, then captures and
// returns the selected 64-bit channel value with a one-cycle done pulse.
module code_arbiter #(
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req0,
  input  logic [CW-1:0] i_cnt0,
  input  logic          i_req1,
  input  logic [CW-1:0] i_cnt1,
  input  logic [63:0]   i_dp_out0,
  input  logic [63:0]   i_dp_out1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_done0,
  output logic          o_done1,
  output logic [63:0]   o_result,
  output logic          o_busy,
  output logic          o_slt,
  output logic          o_en
);

  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_remaining;
  logic          r_owner;
  logic          r_last_srv;

  logic          w_any_req;
  logic          w_pick1;
  logic [CW-1:0] w_cnt_sel;
  logic [DW-1:0] w_dp_sel;

  // Round-robin pick: on a tie the requester that was not served last wins.
  assign w_any_req = i_req0 | i_req1;
  assign w_pick1   = i_req1 & (~i_req0 | ~r_last_srv);
  assign w_cnt_sel = w_pick1 ? i_cnt1 : i_cnt0;
  assign w_dp_sel  = r_owner ? i_dp_out1 : i_dp_out0;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_owner     <= 1'b0;
      r_last_srv  <= 1'b1;
      o_gnt0      <= 1'b0;
      o_gnt1      <= 1'b0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_result    <= '0;
      o_busy      <= 1'b0;
      o_slt       <= 1'b0;
      o_en        <= 1'b0;
    end else begin
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_en <= 1'b0;
          if (w_any_req) begin
            r_owner     <= w_pick1;
            r_last_srv  <= w_pick1;
            r_remaining <= w_cnt_sel;
            o_slt       <= w_pick1;
            o_gnt0      <= ~w_pick1;
            o_gnt1      <= w_pick1;
            o_busy      <= 1'b1;
            if (w_cnt_sel != '0) begin
              o_en    <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_state <= S_CAPTURE;
            end
          end
        end
        S_RUN: begin
          // The last step is the one taken while remaining is 1, so the
          // counter lands on 0 as the FSM leaves and never wraps.
          r_remaining <= r_remaining - CW'(1);
          if (r_remaining == CW'(1)) begin
            o_en    <= 1'b0;
            r_state <= S_CAPTURE;
          end else begin
            o_en    <= 1'b1;
          end
        end
        S_CAPTURE: begin
          o_en     <= 1'b0;
          o_result <= w_dp_sel;
          o_done0  <= ~r_owner;
          o_done1  <= r_owner;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_en    <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output invariants of the handshake.
  a_gnt_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_gnt0 && o_gnt1));
  a_done_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_done0 && o_done1));
  a_gnt_done_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !((o_gnt0 || o_gnt1) && (o_done0 || o_done1)));
  a_en_busy: assert property (@(posedge i_clk) disable iff (i_reset)
    o_en |-> o_busy);
  a_en_slt: assert property (@(posedge i_clk) disable iff (i_reset)
    o_en |-> (o_slt == r_owner));

endmodule

// File: tb/tb_code_arbiter.sv
// Bench for code_arbiter: directed scenarios plus random traffic, with a
// transaction-level reference model feeding a scoreboard queue.
module tb_code_arbiter;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset, req0, req1;
  logic [CW-1:0] cnt0, cnt1;
  logic          gnt0, gnt1, done0, done1, busy, slt, en;
  logic [63:0]   result, dp0, dp1;
  logic          dp_clr;

  always #5 clk = ~clk;

  code_arbiter #(.CW(CW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req0), .i_cnt0(cnt0), .i_req1(req1), .i_cnt1(cnt1),
    .i_dp_out0(dp0), .i_dp_out1(dp1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_result(result), .o_busy(busy), .o_slt(slt), .o_en(en)
  );

  // Datapath stand-in: selected channel steps by one per enabled clock.
  logic [63:0] chan [2];
  assign dp0 = chan[0];
  assign dp1 = chan[1];
  always @(posedge clk) begin
    if (dp_clr) begin
      chan[0] <= 64'd0;
      chan[1] <= 64'd0;
    end else if (en && !reset) begin
      chan[slt] <= chan[slt] + 64'd1;
    end
  end

  typedef struct {
    int          k;
    int          n;
    logic        owner;
    logic [63:0] res;
  } txn_t;
  txn_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (updated on every rising edge).
  int          edge_n = 0;
  int          free_at = 0;
  int          rst_edge = -1;
  bit          started = 1'b0;
  logic        last_m = 1'b1;
  logic        slt_m = 1'b0;
  logic        cur_valid = 1'b0;
  int          cur_k = 0;
  int          cur_n = 0;
  logic        cur_own = 1'b0;
  logic [63:0] chan_m [2];

  // Transaction-level model: decides acceptances and predicts results.
  always @(posedge clk) begin
    int   steps;
    int   n;
    logic who;
    edge_n++;
    if (dp_clr) begin
      chan_m[0] = 64'd0;
      chan_m[1] = 64'd0;
    end
    if (reset) begin
      if (cur_valid && edge_n <= cur_k + cur_n + 1) begin
        steps = edge_n - cur_k - 1;
        if (steps > cur_n) steps = cur_n;
        chan_m[cur_own] = chan_m[cur_own] - 64'(cur_n) + 64'(steps);
        if (sb.size() > 0) void'(sb.pop_back());
      end
      cur_valid = 1'b0;
      last_m    = 1'b1;
      slt_m     = 1'b0;
      free_at   = edge_n + 1;
      rst_edge  = edge_n;
      started   = 1'b1;
    end else if (started && edge_n >= free_at && (req0 || req1)) begin
      who = (req0 && req1) ? ~last_m : req1;
      n   = who ? int'(cnt1) : int'(cnt0);
      chan_m[who] = chan_m[who] + 64'(n);
      sb.push_back('{k: edge_n, n: n, owner: who, res: chan_m[who]});
      cur_valid = 1'b1;
      cur_k     = edge_n;
      cur_n     = n;
      cur_own   = who;
      last_m    = who;
      slt_m     = who;
      free_at   = edge_n + n + 3;
    end
  end

  // Monitor: per-cycle control check and scoreboard pop on each done.
  int en_cnt = 0;
  always @(negedge clk) begin
    logic [6:0] exp_v, act_v;
    int         e;
    txn_t       t;
    if (started) begin
      e     = edge_n;
      act_v = {gnt0, gnt1, en, busy, slt, done0, done1};
      if (cur_valid)
        exp_v = {(e == cur_k) && !cur_own, (e == cur_k) && cur_own,
                 (e >= cur_k) && (e <= cur_k + cur_n - 1),
                 (e >= cur_k) && (e <= cur_k + cur_n + 1),
                 slt_m,
                 (e == cur_k + cur_n + 1) && !cur_own,
                 (e == cur_k + cur_n + 1) && cur_own};
      else
        exp_v = {4'b0000, slt_m, 2'b00};
      chk("ctrl{g0,g1,en,busy,slt,d0,d1}", 64'(act_v), 64'(exp_v));
      if (e == rst_edge) chk("reset_result", result, 64'd0);
      if (gnt0 || gnt1) en_cnt = 0;
      if (en) en_cnt++;
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(done1), 64'(cur_own ^ done1 ^ 1'b1));
        end else begin
          t = sb.pop_front();
          chk("done_owner", 64'(done1), 64'(t.owner));
          chk("result", result, t.res);
          chk("en_cycles", 64'(en_cnt), 64'(t.n));
        end
      end else if (sb.size() > 0 && e > sb[0].k + sb[0].n + 1) begin
        t = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL done_missing: owner %0d n %0d accepted at edge %0d, none by edge %0d",
                 t.owner, t.n, t.k, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic timeout_fail(input string name, input int max);
    checks++;
    errors++;
    $display("FAIL %s: no event within %0d cycles", name, max);
  endtask

  task automatic wait_done(input logic who, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (who ? done1 : done0) return;
    end
    timeout_fail("wait_done", max);
  endtask

  task automatic wait_any_done(output logic who, input int max);
    who = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        who = done1;
        return;
      end
    end
    timeout_fail("wait_any_done", max);
  endtask

  task automatic wait_gnt0(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (gnt0) return;
    end
    timeout_fail("wait_gnt0", max);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeout_fail("wait_idle", max);
  endtask

  task automatic clear_dp();
    dp_clr = 1'b1;
    tick(1);
    dp_clr = 1'b0;
  endtask

  // Stimulus.
  initial begin
    logic who;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cnt0 = '0; cnt1 = '0; dp_clr = 1'b1;
    tick(3);
    reset = 1'b0; dp_clr = 1'b0;
    tick(2);

    // Single request, count 5; count changes after acceptance are ignored.
    req0 = 1'b1; cnt0 = 8'd5;
    tick(1);
    req0 = 1'b0; cnt0 = 8'(($urandom % 200) + 20);
    wait_done(1'b0, 20);
    wait_idle(5);
    tick(2);

    // Tie with counts 3 and 6, each held until its own done.
    clear_dp();
    req0 = 1'b1; req1 = 1'b1; cnt0 = 8'd3; cnt1 = 8'd6;
    wait_done(1'b0, 30);
    req0 = 1'b0;
    wait_done(1'b1, 30);
    req1 = 1'b0;
    tick(2);

    // Second tie with counts 1 and 1.
    clear_dp();
    req0 = 1'b1; req1 = 1'b1; cnt0 = 8'd1; cnt1 = 8'd1;
    wait_any_done(who, 20);
    if (who) req1 = 1'b0; else req0 = 1'b0;
    wait_any_done(who, 20);
    req0 = 1'b0; req1 = 1'b0;
    tick(2);

    // Zero-step request on channel 1.
    req1 = 1'b1; cnt1 = 8'd0;
    tick(1);
    req1 = 1'b0;
    wait_done(1'b1, 10);
    tick(2);

    // Reset during the 4th RUN cycle, then a fresh 2-step request.
    clear_dp();
    req0 = 1'b1; cnt0 = 8'd8;
    wait_gnt0(10);
    req0 = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("dp_chan0_after_reset", chan[0], chan_m[0]);
    req0 = 1'b1; cnt0 = 8'd2;
    tick(1);
    req0 = 1'b0;
    wait_done(1'b0, 10);
    tick(2);

    // Continuous request: back-to-back services.
    clear_dp();
    req0 = 1'b1; cnt0 = 8'd2;
    for (int i = 0; i < 3; i++) wait_done(1'b0, 10);
    req0 = 1'b0;
    wait_idle(5);
    tick(2);

    // Maximum count.
    clear_dp();
    req0 = 1'b1; cnt0 = 8'd255;
    tick(1);
    req0 = 1'b0;
    wait_done(1'b0, 300);
    tick(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req0  = ($urandom_range(0, 2) == 0);
      req1  = ($urandom_range(0, 2) == 0);
      cnt0  = 8'($urandom_range(0, 6));
      cnt1  = 8'($urandom_range(0, 6));
      reset = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    wait_idle(20);
    tick(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
